// File: rtl/cmp_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper
// for the shared signed a<=b comparator scheduler.
package cmp_sched_pkg;

   typedef int unsigned uint_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int WIDTH_DEF   = 32;
   localparam int CNT_W_DEF   = 16;
   localparam int MAX_REQ     = 16;

   // First set bit of vld at or after ptr, wrapping modulo n.
   // Walks from the farthest slot back so the nearest wins.
   function automatic uint_t rr_pick(
      input logic [MAX_REQ-1:0] vld,
      input uint_t              ptr,
      input uint_t              n
   );
      uint_t idx;
      rr_pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (uint_t'(k) < n) begin
            idx = (ptr + uint_t'(k)) % n;
            if (vld[idx[3:0]]) begin
               rr_pick = idx;
            end
         end
      end
   endfunction

endpackage

// File: rtl/signed_lteq_comb.sv
// Pure combinational two's-complement a <= b; kept standalone
// so its netlist can be swapped by the logic optimisation flow.
module signed_lteq_comb
   import cmp_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lteq
);

   logic sign_diff;
   logic mag_le;

   assign sign_diff = a[WIDTH-1] ^ b[WIDTH-1];

   // With equal signs the remaining bits order like unsigned.
   assign mag_le = (a[WIDTH-2:0] <= b[WIDTH-2:0]);

   // Differing signs: a <= b exactly when a is the negative one.
   assign lteq = sign_diff ? a[WIDTH-1] : mag_le;

endmodule

// File: rtl/cmp_lteq_sched.sv
// Round-robin scheduler sharing one signed a<=b comparator
// among NUM_REQ requesters with a registered 1-bit response.
module cmp_lteq_sched
   import cmp_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic                     rsp_lteq,
   output logic                     busy,
   output logic [CNT_W-1:0]         cmp_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t state_q, state_d;

   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   gnt_q;
   logic [IDX_W-1:0]   ptr_next;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   sel_a, sel_b;
   logic               res_q;
   logic               cmp_lteq;
   logic [CNT_W-1:0]   cnt_q;
   logic [MAX_REQ-1:0] vld_ext;
   logic               any_vld;
   logic               in_idle;
   logic               in_eval;
   logic               in_resp;
   logic               hs;
   logic               done;

   assign in_idle = (state_q == IDLE);
   assign in_eval = (state_q == EVAL);
   assign in_resp = (state_q == RESP);

   always_comb begin
      vld_ext = '0;
      vld_ext[NUM_REQ-1:0] = req_valid;
   end

   assign any_vld = |req_valid;

   assign gnt_idx = IDX_W'(rr_pick(vld_ext,
                                   uint_t'(rr_ptr_q),
                                   uint_t'(NUM_REQ)));

   assign sel_a = req_a[gnt_idx*WIDTH +: WIDTH];
   assign sel_b = req_b[gnt_idx*WIDTH +: WIDTH];

   assign ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1))
                   ? '0
                   : gnt_idx + 1'b1;

   // Ready is held low while reset is asserted, even in IDLE.
   assign hs = rst_n & in_idle & any_vld;

   assign done = in_resp & rsp_ready[gnt_q];

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (hs) begin
         req_ready = NUM_REQ'(1) << gnt_idx;
      end
      if (in_resp) begin
         rsp_valid = NUM_REQ'(1) << gnt_q;
      end
   end

   assign rsp_lteq  = in_resp & res_q;
   assign busy      = ~in_idle;
   assign cmp_count = cnt_q;

   signed_lteq_comb #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a    (a_q),
      .b    (b_q),
      .lteq (cmp_lteq)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               state_d = EVAL;
            end
         end
         EVAL: begin
            state_d = RESP;
         end
         RESP: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else if (hs) begin
         rr_ptr_q <= ptr_next;
         gnt_q    <= gnt_idx;
         a_q      <= sel_a;
         b_q      <= sel_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= 1'b0;
      end else if (in_eval) begin
         res_q <= cmp_lteq;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (done && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
